// File: rtl/shared_cell_arbiter.sv
// Round-robin arbiter time-sharing one single-bit cell between NUM_REQ requesters.
// Optional hold-timeout rotation is compiled in with SHARED_CELL_ARB_TIMEOUT_EN.
module shared_cell_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       cell_i,
  input  logic                       cell_o,
  output logic                       rsp_valid,
  output logic                       rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_owner,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("shared_cell_arbiter: NUM_REQ out of range 2..16");
  end
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("shared_cell_arbiter: HOLD_MAX out of range 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_data_q, rsp_data_d;
  logic [IW-1:0]      rsp_owner_q, rsp_owner_d;
  logic               busy_q, busy_d;

  logic               win_vld;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      win_next;
  int unsigned        cand;
  logic               timeout_c;

`ifdef SHARED_CELL_ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic [HW-1:0] hold_inc;

  // Saturating count of cycles the current owner has held the cell.
  assign hold_inc  = (hold_q == HW'(HOLD_MAX)) ? hold_q : hold_q + HW'(1);
  assign timeout_c = (hold_inc == HW'(HOLD_MAX)) && (|(req & ~grant_q));
`else
  assign timeout_c = 1'b0;
`endif

  // First set req bit searching upward from ptr, wrapping.
  always_comb begin : arb_search
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!win_vld && req[IW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end

  assign win_next = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);

  always_comb begin : fsm_next
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
`ifdef SHARED_CELL_ARB_TIMEOUT_EN
    hold_d      = hold_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_SWITCH: begin
        if (win_vld) begin
          state_d = ST_GRANT;
          grant_d = NUM_REQ'(1) << win_idx;
          owner_d = win_idx;
          ptr_d   = win_next;
`ifdef SHARED_CELL_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_GRANT: begin
`ifdef SHARED_CELL_ARB_TIMEOUT_EN
        hold_d = hold_inc;
`endif
        // Release and timeout together still make a single rotation.
        if (!req[owner_q] || timeout_c) begin
          state_d = ST_SWITCH;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_q == ST_GRANT);
    rsp_data_d  = cell_o;
    rsp_owner_d = owner_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
      rsp_owner_q <= '0;
      busy_q      <= 1'b0;
`ifdef SHARED_CELL_ARB_TIMEOUT_EN
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_owner_q <= rsp_owner_d;
      busy_q      <= busy_d;
`ifdef SHARED_CELL_ARB_TIMEOUT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  // Cell input is only ever driven by the registered owner during GRANT.
  assign cell_i    = (state_q == ST_GRANT) ? req_data[owner_q] : 1'b0;
  assign grant     = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_owner = rsp_owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shared_cell_arbiter.sv
// Directed bench for shared_cell_arbiter with a combinational buffer as the shared cell.
module tb_shared_cell_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] req_data;
  logic [3:0] grant;
  logic       cell_i;
  logic       cell_o;
  logic       rsp_valid;
  logic       rsp_data;
  logic [1:0] rsp_owner;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  shared_cell_arbiter #(.NUM_REQ(4), .HOLD_MAX(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .cell_i    (cell_i),
    .cell_o    (cell_o),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_owner (rsp_owner),
    .busy      (busy)
  );

  assign cell_o = cell_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  int seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_data = 4'b0000;
    #3;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_cell_i", 32'(cell_i), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_rsp_owner", 32'(rsp_owner), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_grant", 32'(grant), 32'h0);

    // Single requester 2
    req      = 4'b0100;
    req_data = 4'b0100;
    step();
    check("single_grant", 32'(grant), 32'h4);
    check("single_cell_i", 32'(cell_i), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    check("single_rsp_valid0", 32'(rsp_valid), 32'h0);
    step();
    check("single_rsp_valid1", 32'(rsp_valid), 32'h1);
    check("single_rsp_owner", 32'(rsp_owner), 32'h2);
    check("single_rsp_data", 32'(rsp_data), 32'h1);
    req = 4'b0000;
    step();
    check("single_switch_grant", 32'(grant), 32'h0);
    check("single_switch_busy", 32'(busy), 32'h1);
    check("single_switch_cell_i", 32'(cell_i), 32'h0);
    step();
    check("single_idle_busy", 32'(busy), 32'h0);
    check("single_idle_rsp_valid", 32'(rsp_valid), 32'h0);

    // Round-robin, each owner releases after 3 grant cycles
    pulse_reset();
    req      = 4'b1111;
    req_data = 4'b1010;
    foreach (seq[i]) begin
      step();
      check($sformatf("rr%0d_grant_c1", i), 32'(grant), 32'(4'b0001 << seq[i]));
      check($sformatf("rr%0d_cell_i", i), 32'(cell_i), 32'((4'b1010 >> seq[i]) & 4'b0001));
      step();
      check($sformatf("rr%0d_grant_c2", i), 32'(grant), 32'(4'b0001 << seq[i]));
      check($sformatf("rr%0d_rsp_owner", i), 32'(rsp_owner), 32'(seq[i]));
      step();
      check($sformatf("rr%0d_grant_c3", i), 32'(grant), 32'(4'b0001 << seq[i]));
      req[seq[i]] = 1'b0;
      step();
      check($sformatf("rr%0d_gap", i), 32'(grant), 32'h0);
      req[seq[i]] = 1'b1;
    end
    req = 4'b0000;
    step();
    check("rr_idle_busy", 32'(busy), 32'h0);

    // Owner 3 releases as requester 0 rises, ptr wrapped to 0
    pulse_reset();
    req      = 4'b1000;
    req_data = 4'b0000;
    step();
    check("simul_grant3", 32'(grant), 32'h8);
    step();
    req = 4'b0001;
    step();
    check("simul_switch", 32'(grant), 32'h0);
    step();
    check("simul_grant0", 32'(grant), 32'h1);
    req = 4'b0000;
    step();
    step();

    // Hold timeout with requester 1 arriving at grant cycle 2
    pulse_reset();
    req = 4'b0001;
    step();
    check("to_c1", 32'(grant), 32'h1);
    step();
    check("to_c2", 32'(grant), 32'h1);
    req = 4'b0011;
    for (int k = 3; k <= 8; k++) begin
      step();
      check($sformatf("to_c%0d", k), 32'(grant), 32'h1);
    end
    step();
`ifdef SHARED_CELL_ARB_TIMEOUT_EN
    check("to_switch", 32'(grant), 32'h0);
    step();
    check("to_rotate", 32'(grant), 32'h2);
`else
    check("to_hold9", 32'(grant), 32'h1);
    step();
    check("to_hold10", 32'(grant), 32'h1);
`endif
    req = 4'b0000;
    step();
    step();
    step();

    // Asynchronous reset mid-grant
    pulse_reset();
    req      = 4'b0001;
    req_data = 4'b0001;
    step();
    check("mid_grant", 32'(grant), 32'h1);
    check("mid_cell_i", 32'(cell_i), 32'h1);
    step();
    check("mid_rsp_valid", 32'(rsp_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_cell_i", 32'(cell_i), 32'h0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    req   = 4'b0010;
    step();
    check("post_rst_grant", 32'(grant), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
